hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Stall/flush side of operand hazard handling. The forwarding unit picks bypass sources; this block decides when forwarding cannot help.
- Sits beside the ID stage.
- Drives the PC and IF/ID write enables, the IF/ID flush and the ID/EX bubble.
- Owns the multi-cycle MUL/DIV sequencer, which holds HI/LO readers and new MUL/DIV ops until the result is ready.

Parameters:
- MUL_CYCLES, 4, busy cycles for mult/multu after start.
- DIV_CYCLES, 32, busy cycles for div/divu after start.
- CNT_W, 6, busy-counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-high
- ID_rs  in  5  rs of instruction in ID
- ID_rt  in  5  rt of instruction in ID
- ID_UseRs  in  1  ID instruction reads rs
- ID_UseRt  in  1  ID instruction reads rt
- ID_Branch  in  1  ID instruction compares/jumps on registers in ID (beq/bne/jr)
- ID_BranchTaken  in  1  branch/jump resolved taken in ID
- ID_MulDiv  in  1  ID instruction is mult/multu/div/divu
- ID_IsDiv  in  1  qualifies ID_MulDiv: 1 = div, 0 = mul
- ID_UseHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
- EX_RF_rd  in  5  destination in EX
- EX_RegWrite  in  1  EX writes register file
- EX_MemRead  in  1  EX is a load
- MEM_RF_rd  in  5  destination in MEM
- MEM_MemRead  in  1  MEM is a load
- PC_Write  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  squash fetched instruction
- ID_EX_Flush  out  1  insert bubble into ID/EX
- MD_Start  out  1  one-cycle start pulse to the MUL/DIV datapath
- MD_Busy  out  1  sequencer in BUSY
- MD_Done  out  1  one-cycle pulse when the result is valid
- Perf_StallCnt  out  32  stall-cycle counter
- Perf_FlushCnt  out  32  flush-cycle counter

Behaviour:
- Qualified matches: match_rs(X) = (X_rd != 0) && (X_rd == ID_rs) && ID_UseRs; match_rt is the same with rt.
- Stall conditions, OR'd together:
  - a) load-use: EX_MemRead && match(EX).
  - b) branch on EX ALU result: ID_Branch && EX_RegWrite && !EX_MemRead && match(EX).
  - c) branch on load: ID_Branch && (EX_MemRead && match(EX) || MEM_MemRead && match(MEM)). A load directly before a branch therefore stalls 2 cycles; recomputed each cycle, with no extra state.
  - d) MUL/DIV structural: (ID_MulDiv || ID_UseHiLo) && state != IDLE.
- When stall=1: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0. Stall overrides the branch decision, because the operands are not yet valid.
- When stall=0: PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0, IF_ID_Flush=ID_BranchTaken.
- All four pipeline controls are combinational from inputs and registered state; zero latency.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if ID_MulDiv && !stall, then MD_Start=1 (combinational, same cycle). Next state is BUSY; cnt loads (ID_IsDiv ? DIV_CYCLES : MUL_CYCLES) - 1.
  - BUSY: cnt decrements each cycle; at cnt==0, next state is DONE.
  - DONE: MD_Done=1 for exactly one cycle; next state is IDLE.
- MD_Busy = (state==BUSY).
- Waiting HI/LO readers or MUL/DIV ops stall through BUSY and DONE. They proceed in the first IDLE cycle, so mul gives exactly MUL_CYCLES+1 stall cycles for a dependent mfhi issued immediately after.
- Back-to-back MUL/DIV: the second op starts on the IDLE cycle after DONE; there is never an overlapping start.
- MD_Start is never asserted while stall=1, including when a load-use stall coincides with ID_MulDiv.
- Reset: state=IDLE, cnt=0, perf counters=0.
  - Outputs with idle inputs: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0, MD_Start=0, MD_Busy=0, MD_Done=0.
  - rst asserted in BUSY or DONE returns to IDLE with no MD_Done pulse.
- Register 0 never creates a hazard.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - Perf_StallCnt increments on every cycle with stall=1.
  - Perf_FlushCnt increments on every cycle with IF_ID_Flush=1.
  - Both are 32-bit, saturating at 32'hFFFFFFFF, and cleared by rst.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Decomposition:
- Shared package: FSM state encodings (MD_IDLE, MD_BUSY, MD_DONE), register-index width 5, and the zero-register constant.
- Natural sub-module md_seq: the FSM plus busy counter, with inputs start_req/is_div/stall and outputs MD_Start/MD_Busy/MD_Done/md_block.
- Hazard compare logic stays in the top level.

Test Plan:
- Load-use: EX lw $8 (EX_MemRead=1, EX_RF_rd=8, EX_RegWrite=1), ID add with rs=8 -> exactly 1 cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; the next cycle is clear.
- Branch after load: lw $9 then beq $9,$0 -> stall 2 cycles (EX match, then MEM match); the third cycle with ID_BranchTaken=1 -> IF_ID_Flush=1.
- Register 0: EX_MemRead=1, EX_RF_rd=0, ID_rs=0, ID_UseRs=1 -> no stall.
- MUL then mfhi: mult in ID -> MD_Start pulse; a following mfhi stalls 5 cycles (MUL_CYCLES=4 plus DONE); MD_Done is high on cycle 5; mfhi proceeds on cycle 6.
- Reset mid-divide: rst asserted at BUSY cnt=20 -> next cycle state IDLE, MD_Busy=0, no MD_Done, pipeline enables=1.
- With HAZARD_PERF_EN: 3 stall cycles plus 1 taken branch -> Perf_StallCnt=3, Perf_FlushCnt=1. Without the macro: both read 0.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the hazard stall/flush controller and its
// MUL/DIV sequencer.
package hazard_stall_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // A producer only matters if it targets a real register the consumer reads.
  function automatic logic reg_match(input logic [REG_W-1:0] src_rd,
                                     input logic [REG_W-1:0] id_r,
                                     input logic             use_r);
    return (src_rd != REG_ZERO) && (src_rd == id_r) && use_r;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_seq.sv
// MUL/DIV sequencer: IDLE -> BUSY (counted) -> DONE -> IDLE. md_block is high
// whenever a new MUL/DIV op or HI/LO access must wait.
module hazard_stall_ctrl_md_seq
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start_req,
  input  logic is_div,
  input  logic stall,
  output logic MD_Start,
  output logic MD_Busy,
  output logic MD_Done,
  output logic md_block
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    MD_Start = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        // stall already covers load-use, so a held op never starts early
        if (start_req && !stall) begin
          MD_Start = 1'b1;
          state_d  = MD_BUSY;
          cnt_d    = is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) state_d = MD_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  assign MD_Busy  = (state_q == MD_BUSY);
  assign MD_Done  = (state_q == MD_DONE) && !rst;
  assign md_block = (state_q != MD_IDLE);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall/flush controller with MUL/DIV sequencer.
// Optional stall/flush performance counters built when HAZARD_PERF_EN is defined.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic             ID_MulDiv,
  input  logic             ID_IsDiv,
  input  logic             ID_UseHiLo,
  input  logic [REG_W-1:0] EX_RF_rd,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] MEM_RF_rd,
  input  logic             MEM_MemRead,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MD_Start,
  output logic             MD_Busy,
  output logic             MD_Done,
  output logic [31:0]      Perf_StallCnt,
  output logic [31:0]      Perf_FlushCnt
);

  logic ex_match, mem_match;
  logic load_use, br_on_alu, br_on_load, md_stall;
  logic md_block, stall;

  assign ex_match  = reg_match(EX_RF_rd, ID_rs, ID_UseRs)  || reg_match(EX_RF_rd, ID_rt, ID_UseRt);
  assign mem_match = reg_match(MEM_RF_rd, ID_rs, ID_UseRs) || reg_match(MEM_RF_rd, ID_rt, ID_UseRt);

  assign load_use   = EX_MemRead && ex_match;
  assign br_on_alu  = ID_Branch && EX_RegWrite && !EX_MemRead && ex_match;
  assign br_on_load = ID_Branch && ((EX_MemRead && ex_match) || (MEM_MemRead && mem_match));
  assign md_stall   = (ID_MulDiv || ID_UseHiLo) && md_block;
  assign stall      = load_use || br_on_alu || br_on_load || md_stall;

  // Operands are not valid while stalled, so a stall masks the taken branch.
  assign PC_Write    = !stall;
  assign IF_ID_Write = !stall;
  assign ID_EX_Flush = stall;
  assign IF_ID_Flush = !stall && ID_BranchTaken;

  hazard_stall_ctrl_md_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_seq (
    .clk       (clk),
    .rst       (rst),
    .start_req (ID_MulDiv),
    .is_div    (ID_IsDiv),
    .stall     (stall),
    .MD_Start  (MD_Start),
    .MD_Busy   (MD_Busy),
    .MD_Done   (MD_Done),
    .md_block  (md_block)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (IF_ID_Flush && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign Perf_StallCnt = stall_cnt_q;
  assign Perf_FlushCnt = flush_cnt_q;
`else
  assign Perf_StallCnt = 32'd0;
  assign Perf_FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: timestamp-based reference model of stall rules and the
// MUL/DIV occupancy window, directed scenarios plus randomized traffic.
module tb_hazard_stall_ctrl;

  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 32;

  logic        clk, rst;
  logic [4:0]  ID_rs, ID_rt, EX_RF_rd, MEM_RF_rd;
  logic        ID_UseRs, ID_UseRt, ID_Branch, ID_BranchTaken;
  logic        ID_MulDiv, ID_IsDiv, ID_UseHiLo;
  logic        EX_RegWrite, EX_MemRead, MEM_MemRead;
  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
  logic        MD_Start, MD_Busy, MD_Done;
  logic [31:0] Perf_StallCnt, Perf_FlushCnt;

  hazard_stall_ctrl #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken),
    .ID_MulDiv(ID_MulDiv), .ID_IsDiv(ID_IsDiv), .ID_UseHiLo(ID_UseHiLo),
    .EX_RF_rd(EX_RF_rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .MEM_RF_rd(MEM_RF_rd), .MEM_MemRead(MEM_MemRead),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .MD_Start(MD_Start), .MD_Busy(MD_Busy), .MD_Done(MD_Done),
    .Perf_StallCnt(Perf_StallCnt), .Perf_FlushCnt(Perf_FlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: the last accepted MUL/DIV start cycle and its length.
  // The unit is occupied for cycles (md_s, md_s+len+1]; DONE is the last one.
  int cyc    = 0;
  int md_s   = -1000;
  int md_len = 0;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;
  logic [6:0] last_got;  // {PC_W, IFID_W, IFID_F, IDEX_F, Start, Busy, Done}

  function automatic bit hits(input logic [4:0] rd);
    return (rd != 5'd0) && ((ID_UseRs && rd == ID_rs) || (ID_UseRt && rd == ID_rt));
  endfunction

  task automatic set_idle();
    ID_rs = 0; ID_rt = 0; ID_UseRs = 0; ID_UseRt = 0;
    ID_Branch = 0; ID_BranchTaken = 0; ID_MulDiv = 0; ID_IsDiv = 0; ID_UseHiLo = 0;
    EX_RF_rd = 0; EX_RegWrite = 0; EX_MemRead = 0; MEM_RF_rd = 0; MEM_MemRead = 0;
  endtask

  // Check one cycle against the model, then advance one clock.
  task automatic step(input string name);
    bit occupied, busy, done, stall, start, flush;
    logic [6:0]  exp_v;
    logic [63:0] exp_p;
    #1;
    occupied = (cyc > md_s) && (cyc <= md_s + md_len + 1);
    busy     = (cyc > md_s) && (cyc <= md_s + md_len);
    done     = (cyc == md_s + md_len + 1) && !rst;
    stall    = (EX_MemRead && hits(EX_RF_rd))
            || (ID_Branch && EX_RegWrite && !EX_MemRead && hits(EX_RF_rd))
            || (ID_Branch && MEM_MemRead && hits(MEM_RF_rd))
            || ((ID_MulDiv || ID_UseHiLo) && occupied);
    start    = ID_MulDiv && !stall && !occupied;
    flush    = !stall && ID_BranchTaken;
    exp_v    = {!stall, !stall, flush, stall, start, busy, done};
    last_got = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Start, MD_Busy, MD_Done};
    checks++;
    if (last_got !== exp_v)
      $display("FAIL %s ctrl cyc=%0d: got %b want %b", name, cyc, last_got, exp_v);
    else passed++;
`ifdef HAZARD_PERF_EN
    exp_p = {32'(m_stall_cnt), 32'(m_flush_cnt)};
`else
    exp_p = 64'd0;
`endif
    checks++;
    if ({Perf_StallCnt, Perf_FlushCnt} !== exp_p)
      $display("FAIL %s perf cyc=%0d: got %0d/%0d want %0d/%0d", name, cyc,
               Perf_StallCnt, Perf_FlushCnt, exp_p[63:32], exp_p[31:0]);
    else passed++;
    $display("cyc %0d %s: ctrl=%b perf=%0d/%0d", cyc, name, last_got, Perf_StallCnt, Perf_FlushCnt);
    @(posedge clk);
    if (rst) begin
      md_s = -1000; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (start) begin md_s = cyc; md_len = ID_IsDiv ? DIV_CYCLES : MUL_CYCLES; end
      m_stall_cnt += int'(stall);
      m_flush_cnt += int'(flush);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic expect_ctrl(input string name, input logic [6:0] want);
    checks++;
    if (last_got !== want) $display("FAIL %s: got %b want %b", name, last_got, want);
    else passed++;
  endtask

  task automatic test_reset();
    set_idle(); rst = 1;
    @(posedge clk); @(negedge clk);
    step("reset_hold");
    rst = 0;
    step("reset_idle");
    expect_ctrl("reset_outputs", 7'b1100000);
  endtask

  task automatic test_load_use();
    set_idle();
    EX_MemRead = 1; EX_RegWrite = 1; EX_RF_rd = 8; ID_rs = 8; ID_UseRs = 1;
    step("load_use_stall");
    expect_ctrl("load_use_stall", 7'b0001000);
    EX_MemRead = 0; EX_RegWrite = 0; EX_RF_rd = 0; MEM_MemRead = 1; MEM_RF_rd = 8;
    step("load_use_clear");
    expect_ctrl("load_use_clear", 7'b1100000);
  endtask

  task automatic test_branch_load();
    set_idle();
    ID_Branch = 1; ID_BranchTaken = 1; ID_rs = 9; ID_UseRs = 1; ID_UseRt = 1;
    EX_MemRead = 1; EX_RegWrite = 1; EX_RF_rd = 9;
    step("br_load_ex");
    expect_ctrl("br_load_ex", 7'b0001000);
    EX_MemRead = 0; EX_RegWrite = 0; EX_RF_rd = 0; MEM_MemRead = 1; MEM_RF_rd = 9;
    step("br_load_mem");
    expect_ctrl("br_load_mem", 7'b0001000);
    MEM_MemRead = 0; MEM_RF_rd = 0;
    step("br_load_taken");
    expect_ctrl("br_load_taken", 7'b1110000);
    set_idle();
  endtask

  task automatic test_reg0();
    set_idle();
    EX_MemRead = 1; EX_RegWrite = 1; EX_RF_rd = 0; ID_rs = 0; ID_UseRs = 1; ID_Branch = 1;
    step("reg0");
    expect_ctrl("reg0_no_stall", 7'b1100000);
    set_idle();
  endtask

  task automatic test_mul_mfhi();
    set_idle();
    ID_MulDiv = 1;
    step("mul_start");
    expect_ctrl("mul_start", 7'b1100100);
    ID_MulDiv = 0; ID_UseHiLo = 1;
    for (int i = 1; i <= 5; i++) begin
      step("mfhi_wait");
      expect_ctrl("mfhi_wait", (i == 5) ? 7'b0001001 : 7'b0001010);
    end
    step("mfhi_go");
    expect_ctrl("mfhi_go", 7'b1100000);
    set_idle();
  endtask

  task automatic test_back_to_back();
    set_idle();
    ID_MulDiv = 1;
    step("b2b_first");
    for (int i = 1; i <= 5; i++) step("b2b_hold");
    step("b2b_second");
    expect_ctrl("b2b_second_start", 7'b1100100);
    set_idle();
    for (int i = 0; i < 5; i++) step("b2b_drain");
  endtask

  task automatic test_reset_mid_div();
    set_idle();
    ID_MulDiv = 1; ID_IsDiv = 1;
    step("div_start");
    set_idle();
    for (int i = 1; i <= 11; i++) step("div_busy");
    rst = 1;
    step("div_rst");
    expect_ctrl("div_rst_busy", 7'b1100010);
    rst = 0;
    step("div_after_rst");
    expect_ctrl("div_after_rst", 7'b1100000);
  endtask

  task automatic test_perf();
    logic [31:0] want_s, want_f;
    set_idle(); rst = 1;
    step("perf_rst");
    rst = 0;
    EX_MemRead = 1; EX_RegWrite = 1; EX_RF_rd = 3; ID_rt = 3; ID_UseRt = 1;
    for (int i = 0; i < 3; i++) step("perf_stall");
    set_idle(); ID_BranchTaken = 1;
    step("perf_flush");
    set_idle();
    step("perf_idle");
`ifdef HAZARD_PERF_EN
    want_s = 32'd3; want_f = 32'd1;
`else
    want_s = 32'd0; want_f = 32'd0;
`endif
    checks++;
    if (Perf_StallCnt !== want_s || Perf_FlushCnt !== want_f)
      $display("FAIL perf_counts: got %0d/%0d want %0d/%0d", Perf_StallCnt, Perf_FlushCnt, want_s, want_f);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 63) == 0);
      ID_rs          = 5'($urandom_range(0, 3));
      ID_rt          = 5'($urandom_range(0, 3));
      ID_UseRs       = 1'($urandom);
      ID_UseRt       = 1'($urandom);
      ID_Branch      = ($urandom_range(0, 3) == 0);
      ID_BranchTaken = ID_Branch && 1'($urandom);
      ID_MulDiv      = ($urandom_range(0, 3) == 0);
      ID_IsDiv       = ($urandom_range(0, 5) == 0);
      ID_UseHiLo     = !ID_MulDiv && ($urandom_range(0, 3) == 0);
      EX_RF_rd       = 5'($urandom_range(0, 3));
      EX_RegWrite    = 1'($urandom);
      EX_MemRead     = EX_RegWrite && ($urandom_range(0, 2) == 0);
      MEM_RF_rd      = 5'($urandom_range(0, 3));
      MEM_MemRead    = ($urandom_range(0, 2) == 0);
      step("random");
    end
    rst = 0;
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_load();
    test_reg0();
    test_mul_mfhi();
    test_back_to_back();
    test_reset_mid_div();
    test_perf();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
